led_pattern_counter: RTL and testbench
======================================

// Module: led_pattern_counter
// PURPOSE
//   Parametrised prescaled LED display counter for the Alchitry Au/IO boards.
//   Divides clk down to a tick rate and advances a counter or pattern on each tick.
//   Supports up/down binary, Gray-coded and single-LED "bounce" patterns, plus
//   synchronous load and pause. Drives the on-board and IO-board LED banks from au_top.
// PARAMETERS
//   CLK_HZ   100_000_000  input clock frequency in Hz
//   TICK_HZ  10           pattern update rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2 required
//   WIDTH    24           counter width in bits
//   LED_W    8            LED bank width for pattern output (LED_W <= WIDTH)
// PORTS
//   clk       in   1        system clock
//   rst       in   1        asynchronous reset, active-high
//   en        in   1        1 = run prescaler; 0 = pause (all state holds)
//   dir       in   1        0 = count up, 1 = count down (binary/Gray modes)
//   mode      in   2        00 binary, 01 Gray, 10 bounce, 11 hold
//   load      in   1        synchronous load strobe
//   load_val  in   WIDTH    value loaded into count
//   count     out  WIDTH    binary counter value (registered)
//   led       out  LED_W    pattern output
//   tick      out  1        one-cycle pulse when the pattern advances
//   wrap      out  1        one-cycle pulse coincident with tick on wrap/reversal
// BEHAVIOUR
//   Reset (async, rst=1): pre=0, count=0, tick=0, wrap=0, pos=0, bdir=up.
//     led=0 in modes 00/01/11; led=1 in mode 10.
//   Priority per edge: rst > load > en/tick logic.
//   load=1: count<=load_val, pre<=0, tick<=0, wrap<=0; pos and bdir unchanged.
//     load works while en=0.
//   en=0: pre, count, pos and bdir hold. tick and wrap go to 0 on the next edge.
//   en=1, pre<DIV-1: pre<=pre+1; tick<=0; wrap<=0.
//   en=1, pre==DIV-1: pre<=0; tick<=1; the advance below happens on the same edge.
//     New count/led and tick are visible together, so there are exactly DIV clocks
//     between ticks.
//   Advance by mode (mode is sampled at the tick edge):
//     00/01: dir=0 -> count+1 (mod 2^WIDTH); dir=1 -> count-1.
//            wrap<=1 when the step is all-ones->0 (up) or 0->all-ones (down).
//     10:    count holds. pos steps toward LED_W-1 (bdir=up) or toward 0 (down).
//            On reaching an end, bdir flips. wrap<=1 on the edge where pos lands on
//            0 or LED_W-1 (after the first move out of reset).
//     11:    count, pos and bdir hold. tick still pulses; wrap=0.
//   led (combinational from registers):
//     00/11: count[LED_W-1:0]
//     01:    g[LED_W-1:0], where g = count ^ (count>>1)
//     10:    one-hot (1 << pos)
//   A mode change mid-interval does not disturb pre. led follows the new mode
//   immediately; the counter/pattern advances at the next tick.
//   Reset asserted mid-interval clears pre, so the next tick occurs DIV clocks
//   after reset release.
// CONFIGURATION
//   LED_PWM_EN defined:
//     - Adds parameter BRIGHT (default 8, range 0..15) and a free-running 4-bit
//       pwm counter (reset 0).
//     - led = pattern & {LED_W{pwm < BRIGHT}}. BRIGHT=0 -> LEDs off; BRIGHT=15 ->
//       15/16 duty.
//     - count, tick and wrap are unaffected.
//   LED_PWM_EN undefined: led = pattern at full duty; no pwm counter is built.
// TESTING (CLK_HZ=100, TICK_HZ=10 -> DIV=10; WIDTH=8, LED_W=4)
//   - Reset, en=1, mode=00, dir=0: first tick 10 clocks after rst falls;
//     count 0,1,2 on successive ticks 10 clocks apart.
//   - load_val=8'hFF, load, then 1 tick up: count=00 and wrap=1 for 1 cycle
//     with tick. dir=1 from 00: count=FF, wrap=1.
//   - mode=01, count=8'h05: led=4'b0111. Next tick -> count=06, led=4'b0101.
//   - mode=10 from reset: led 0001,0010,0100,1000 (wrap=1),0100,0010,0001 (wrap=1).
//   - en=0 for 25 clocks mid-interval: no tick and count frozen. Resumes with the
//     remaining interval. Pulse rst mid-interval: all outputs return to reset values
//     immediately.
//   - LED_PWM_EN, BRIGHT=4, led pattern 1111: led high 4 of every 16 clocks.

Source files
------------

// File: rtl/led_pattern_counter.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_counter
//  Description : Prescaled LED display counter. Divides clk down to a tick
//                rate (DIV = CLK_HZ / TICK_HZ clocks per tick) and on every
//                tick advances either a binary up/down counter (shown as
//                binary or Gray code) or a single-LED "bounce" pattern.
//                Supports synchronous load and pause.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_HZ    input clock frequency in Hz
//    TICK_HZ   pattern update rate in Hz (CLK_HZ / TICK_HZ must be >= 2)
//    WIDTH     counter width in bits
//    LED_W     LED bank width (LED_W <= WIDTH)
//    BRIGHT    PWM brightness 0..15 (only when LED_PWM_EN is defined)
//  Ports
//    clk       system clock
//    rst       asynchronous reset, active-high
//    en        1 = run prescaler, 0 = pause (all state holds)
//    dir       0 = count up, 1 = count down (binary/Gray modes)
//    mode      00 binary, 01 Gray, 10 bounce, 11 hold
//    load      synchronous load strobe (works while paused)
//    load_val  value loaded into count
//    count     registered binary counter value
//    led       pattern output (combinational from registers)
//    tick      one-cycle pulse when the pattern advances
//    wrap      one-cycle pulse with tick on counter wrap / bounce reversal
//  Configuration macro
//    LED_PWM_EN  when defined, adds a free-running 4-bit PWM counter and
//                parameter BRIGHT; led is gated to BRIGHT/16 duty.
// ============================================================================
module led_pattern_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int WIDTH   = 24,
  parameter int LED_W   = 8
`ifdef LED_PWM_EN
  ,
  parameter int BRIGHT  = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic             wrap
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_DIV   = CLK_HZ / TICK_HZ;
  localparam int c_PRE_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;

  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(c_DIV - 1);
  localparam logic [c_POS_W-1:0] c_POS_MAX = c_POS_W'(LED_W - 1);
  localparam logic [c_POS_W-1:0] c_POS_MIN = '0;
  localparam logic [LED_W-1:0]   c_ONE     = LED_W'(1);

  localparam logic [1:0] c_MODE_BIN    = 2'b00;
  localparam logic [1:0] c_MODE_GRAY   = 2'b01;
  localparam logic [1:0] c_MODE_BOUNCE = 2'b10;
  localparam logic [1:0] c_MODE_HOLD   = 2'b11;

  // Bounce direction state
  typedef enum logic {
    BDIR_UP   = 1'b0,
    BDIR_DOWN = 1'b1
  } bdir_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [c_PRE_W-1:0] r_pre;
  logic [WIDTH-1:0]   r_count;
  logic [c_POS_W-1:0] r_pos;
  bdir_t              r_bdir;
  logic               r_tick;
  logic               r_wrap;

  // --------------------------------------------------------------------------
  // Next-state helpers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   w_count_step;
  logic               w_count_wrap;
  logic [c_POS_W-1:0] w_pos_next;
  bdir_t              w_bdir_next;
  logic               w_bounce_wrap;
  logic [LED_W-1:0]   w_gray;
  logic [LED_W-1:0]   w_onehot;
  logic [LED_W-1:0]   w_pattern;
  logic               w_pre_last;

  assign w_pre_last = (r_pre == c_PRE_MAX);

  // Binary step and its wrap condition depend only on dir and the current count
  always_comb begin
    w_count_step = r_count;
    w_count_wrap = 1'b0;
    if (dir) begin
      w_count_step = r_count - 1'b1;
      w_count_wrap = (r_count == '0);
    end else begin
      w_count_step = r_count + 1'b1;
      w_count_wrap = &r_count;
    end
  end

  // Bounce: step pos one place in the current direction. Whenever pos lands
  // on an end the direction flips and wrap fires. The outward-facing guard
  // cases keep pos inside the bank even if the direction were ever stale.
  always_comb begin
    w_pos_next    = r_pos;
    w_bdir_next   = r_bdir;
    w_bounce_wrap = 1'b0;
    if (LED_W > 1) begin
      if (r_bdir == BDIR_UP) begin
        if (r_pos >= c_POS_MAX) begin
          w_pos_next = r_pos - 1'b1;
        end else begin
          w_pos_next = r_pos + 1'b1;
        end
      end else begin
        if (r_pos == c_POS_MIN) begin
          w_pos_next = r_pos + 1'b1;
        end else begin
          w_pos_next = r_pos - 1'b1;
        end
      end

      if (w_pos_next == c_POS_MAX) begin
        w_bdir_next   = BDIR_DOWN;
        w_bounce_wrap = 1'b1;
      end else if (w_pos_next == c_POS_MIN) begin
        w_bdir_next   = BDIR_UP;
        w_bounce_wrap = 1'b1;
      end
    end
  end

  // Gray code of the low LED_W bits: g[i] = count[i] ^ count[i+1].
  // When the LED bank spans the whole counter the top bit has no upper
  // neighbour, so it passes through unchanged.
  generate
    if (LED_W < WIDTH) begin : g_gray_part
      assign w_gray = r_count[LED_W-1:0] ^ r_count[LED_W:1];
    end else begin : g_gray_full
      assign w_gray = r_count[LED_W-1:0] ^ {1'b0, r_count[LED_W-1:1]};
    end
  endgenerate

  assign w_onehot = c_ONE << r_pos;

  // led follows mode immediately; only the advance waits for a tick
  always_comb begin
    w_pattern = r_count[LED_W-1:0];
    case (mode)
      c_MODE_BIN:    w_pattern = r_count[LED_W-1:0];
      c_MODE_GRAY:   w_pattern = w_gray;
      c_MODE_BOUNCE: w_pattern = w_onehot;
      c_MODE_HOLD:   w_pattern = r_count[LED_W-1:0];
      default:       w_pattern = r_count[LED_W-1:0];
    endcase
  end

  // --------------------------------------------------------------------------
  // Prescaler, counter and bounce state
  // Priority: rst > load > pause > prescale/advance
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre   <= '0;
      r_count <= '0;
      r_pos   <= '0;
      r_bdir  <= BDIR_UP;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      // pos/bdir deliberately untouched so a bounce in progress continues
      r_count <= load_val;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (!en) begin
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (!w_pre_last) begin
      r_pre   <= r_pre + 1'b1;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      // Advance lands on the same edge as tick so both become visible together
      r_pre   <= '0;
      r_tick  <= 1'b1;
      case (mode)
        c_MODE_BIN, c_MODE_GRAY: begin
          r_count <= w_count_step;
          r_wrap  <= w_count_wrap;
        end
        c_MODE_BOUNCE: begin
          r_pos   <= w_pos_next;
          r_bdir  <= w_bdir_next;
          r_wrap  <= w_bounce_wrap;
        end
        default: begin
          r_wrap  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count = r_count;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

`ifdef LED_PWM_EN
  // Free-running brightness PWM; runs regardless of en so LEDs stay lit
  // at the chosen duty while paused.
  localparam logic [4:0] c_BRIGHT = 5'(BRIGHT);

  logic [3:0] r_pwm;
  logic       w_pwm_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  assign w_pwm_on = ({1'b0, r_pwm} < c_BRIGHT);
  assign led      = w_pattern & {LED_W{w_pwm_on}};
`else
  assign led = w_pattern;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_counter
//  Description : Self-checking bench for led_pattern_counter with
//                CLK_HZ=100, TICK_HZ=10 (DIV=10), WIDTH=8, LED_W=4.
//                Expected tick results are queued when stimulus is applied
//                and compared as the DUT produces each tick.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_pattern_counter;

  localparam int c_WIDTH  = 8;
  localparam int c_LED_W  = 4;
  localparam int c_BUDGET = 40;

  logic               clk;
  logic               rst;
  logic               en;
  logic               dir;
  logic [1:0]         mode;
  logic               load;
  logic [c_WIDTH-1:0] load_val;
  logic [c_WIDTH-1:0] count;
  logic [c_LED_W-1:0] led;
  logic               tick;
  logic               wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [c_WIDTH-1:0] count;
    logic [c_LED_W-1:0] led;
    logic               wrap;
    int                 gap;
  } exp_t;

  exp_t sb[$];

  led_pattern_counter #(
    .CLK_HZ  (100),
    .TICK_HZ (10),
    .WIDTH   (c_WIDTH),
    .LED_W   (c_LED_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .led      (led),
    .tick     (tick),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle 1ns so inputs change and outputs are sampled
  // away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [c_WIDTH-1:0] c, input logic [c_LED_W-1:0] l,
                          input logic w, input int g);
    exp_t e;
    e.count = c;
    e.led   = l;
    e.wrap  = w;
    e.gap   = g;
    sb.push_back(e);
  endtask

  // Consume queued expectations, one per DUT tick
  task automatic drain_scoreboard(input string tag);
    exp_t e;
    int   n;
    bit   seen;
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      n    = 0;
      seen = 1'b0;
      while (!seen && n < c_BUDGET) begin
        step();
        n++;
        if (tick === 1'b1) begin
          seen = 1'b1;
        end else begin
          checks++;
          if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL %s wrap_without_tick: got %b want 0 (cycle %0d)", tag, wrap, n);
          end
        end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL %s tick_timeout: no tick in %0d cycles", tag, c_BUDGET);
      end else begin
        checks++;
        if (n !== e.gap) begin
          errors++;
          $display("FAIL %s tick_gap: got %0d want %0d", tag, n, e.gap);
        end
        checks++;
        if (count !== e.count) begin
          errors++;
          $display("FAIL %s count: got %h want %h", tag, count, e.count);
        end
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL %s led: got %b want %b", tag, led, e.led);
        end
        checks++;
        if (wrap !== e.wrap) begin
          errors++;
          $display("FAIL %s wrap: got %b want %b", tag, wrap, e.wrap);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; dir = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
    step();
    step();
    checks++;
    if (count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h want 00", count); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    checks++;
    if (led !== 4'b0000) begin errors++; $display("FAIL reset_led_bin: got %b want 0000", led); end
    mode = 2'b10;
    #1;
    checks++;
    if (led !== 4'b0001) begin errors++; $display("FAIL reset_led_bounce: got %b want 0001", led); end
    mode = 2'b00;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_binary_up();
    push_exp(8'h01, 4'h1, 1'b0, 10);
    push_exp(8'h02, 4'h2, 1'b0, 10);
    push_exp(8'h03, 4'h3, 1'b0, 10);
    drain_scoreboard("bin_up");
  endtask

  task automatic test_wrap();
    load_val = 8'hFF;
    load     = 1'b1;
    step();
    load     = 1'b0;
    checks++;
    if (count !== 8'hFF) begin errors++; $display("FAIL load_ff: got %h want ff", count); end
    push_exp(8'h00, 4'h0, 1'b1, 10);
    drain_scoreboard("wrap_up");
    dir = 1'b1;
    push_exp(8'hFF, 4'hF, 1'b1, 10);
    push_exp(8'hFE, 4'hE, 1'b0, 10);
    drain_scoreboard("wrap_down");
    dir = 1'b0;
  endtask

  task automatic test_gray();
    load_val = 8'h05;
    load     = 1'b1;
    step();
    load     = 1'b0;
    mode     = 2'b01;
    #1;
    checks++;
    if (led !== 4'b0111) begin errors++; $display("FAIL gray_05: got %b want 0111", led); end
    push_exp(8'h06, 4'b0101, 1'b0, 10);
    drain_scoreboard("gray");
    mode = 2'b00;
  endtask

  task automatic test_bounce();
    rst = 1'b1;
    step();
    rst  = 1'b0;
    mode = 2'b10;
    #1;
    checks++;
    if (led !== 4'b0001) begin errors++; $display("FAIL bounce_start: got %b want 0001", led); end
    push_exp(8'h00, 4'b0010, 1'b0, 10);
    push_exp(8'h00, 4'b0100, 1'b0, 10);
    push_exp(8'h00, 4'b1000, 1'b1, 10);
    push_exp(8'h00, 4'b0100, 1'b0, 10);
    push_exp(8'h00, 4'b0010, 1'b0, 10);
    push_exp(8'h00, 4'b0001, 1'b1, 10);
    push_exp(8'h00, 4'b0010, 1'b0, 10);
    drain_scoreboard("bounce");
  endtask

  task automatic test_hold();
    mode = 2'b11;
    push_exp(8'h00, 4'b0000, 1'b0, 10);
    drain_scoreboard("hold");
    mode = 2'b10;
    #1;
    checks++;
    if (led !== 4'b0010) begin errors++; $display("FAIL hold_pos_kept: got %b want 0010", led); end
    mode = 2'b00;
  endtask

  task automatic test_pause();
    int ticks_seen;
    ticks_seen = 0;
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (tick === 1'b1) ticks_seen++;
    end
    checks++;
    if (ticks_seen !== 0) begin errors++; $display("FAIL pause_ticks: got %0d want 0", ticks_seen); end
    checks++;
    if (count !== 8'h00) begin errors++; $display("FAIL pause_count: got %h want 00", count); end
    en = 1'b1;
    push_exp(8'h01, 4'h1, 1'b0, 6);
    drain_scoreboard("pause_resume");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (count !== 8'h01) begin errors++; $display("FAIL pre_reset_count: got %h want 01", count); end
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 8'h00) begin errors++; $display("FAIL async_reset_count: got %h want 00", count); end
    checks++;
    if (led !== 4'h0) begin errors++; $display("FAIL async_reset_led: got %b want 0000", led); end
    step();
    rst = 1'b0;
    push_exp(8'h01, 4'h1, 1'b0, 10);
    drain_scoreboard("reset_mid");
  endtask

  task automatic test_back_to_back();
    en       = 1'b0;
    load_val = 8'h7F;
    load     = 1'b1;
    step();
    load     = 1'b0;
    checks++;
    if (count !== 8'h7F) begin errors++; $display("FAIL load_paused: got %h want 7f", count); end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (count !== 8'h7F) begin errors++; $display("FAIL load_paused_hold: got %h want 7f", count); end
    en = 1'b1;
    push_exp(8'h80, 4'h0, 1'b0, 10);
    push_exp(8'h81, 4'h1, 1'b0, 10);
    drain_scoreboard("back_to_back");
  endtask

  initial begin
    test_reset();
    test_binary_up();
    test_wrap();
    test_gray();
    test_bounce();
    test_hold();
    test_pause();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
